// File: rtl/serial_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared encodings and helpers for the serial pattern detector:
//             FSM state codes, overlap-mode codes and a saturating increment.
//  Revision : 1.0  initial release
// ============================================================================
package serial_pkg;

   // One-hot state codes leave spare encodings, so a corrupted state
   // register can be detected and recovered.
   localparam logic [1:0] FILL  = 2'b01;
   localparam logic [1:0] ARMED = 2'b10;

   localparam logic MODE_FRAMED  = 1'b0;
   localparam logic MODE_OVERLAP = 1'b1;

   // Increment val, holding at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input int unsigned width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max_v) ? val : (val + 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_pattern_detector_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_detector_if
//  Purpose  : Bundles the serial input qualifiers and the detector results.
//  Ports    : Din, din_valid, overlap, clear (master -> slave)
//             match, error, match_count     (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface serial_pattern_detector_if #(
   parameter int CNT_W = 8
);
   logic             Din;
   logic             din_valid;
   logic             overlap;
   logic             clear;
   logic             match;
   logic             error;
   logic [CNT_W-1:0] match_count;

   modport master (
      output Din, din_valid, overlap, clear,
      input  match, error, match_count
   );

   modport slave (
      input  Din, din_valid, overlap, clear,
      output match, error, match_count
   );
endinterface
`default_nettype wire

// File: rtl/serial_pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sat_counter
//  Purpose  : Saturating up-counter with synchronous clear.
//  Ports    : clk, rst_n (async, active low), inc_i, clr_i (clr wins),
//             count_o (WIDTH bits, holds at all-ones)
//  Revision : 1.0  initial release
// ============================================================================
module serial_sat_counter
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             inc_i,
   input  wire logic             clr_i,
   output logic      [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [31:0]      w_inc;

   assign w_inc = sat_inc(32'(count_q), WIDTH);

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = w_inc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_detector
//  Purpose  : Detects a PAT_W-bit pattern (MSB first) in a qualified serial
//             stream, in framed or sliding-window mode. Mealy match strobe,
//             saturating match counter and sticky error flag.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low reset
//             bus    - slave side of serial_pattern_detector_if
//  Revision : 1.0  initial release
// ============================================================================
module serial_pattern_detector
   import serial_pkg::*;
#(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b111,
   parameter int               CNT_W   = 8
) (
   input  wire logic clk,
   input  wire logic reset,
   serial_pattern_detector_if.slave bus
);

   localparam int POS_W = $clog2(PAT_W);

   logic [1:0]       state_q,   state_d;
   logic [POS_W-1:0] pos_q,     pos_d;
   logic [PAT_W-2:0] history_q, history_d;
   logic             error_q,   error_d;
   logic             overlap_q;

   logic             w_mode_chg;
   logic [PAT_W-1:0] w_cand;
   logic             w_match;

   // A mode switch abandons whatever was accumulated under the old mode.
   assign w_mode_chg = (bus.overlap != overlap_q);
   assign w_cand     = {history_q, bus.Din};

   assign w_match = reset && !bus.clear && bus.din_valid && !w_mode_chg &&
                    (state_q == ARMED) && (w_cand == PATTERN);

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      history_d = history_q;
      error_d   = error_q;

      if (bus.clear || w_mode_chg) begin
         state_d   = FILL;
         pos_d     = '0;
         history_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (bus.din_valid) begin
                  history_d = w_cand[PAT_W-2:0];
                  pos_d     = pos_q + 1'b1;
                  if (pos_q == POS_W'(PAT_W-2)) begin
                     state_d = ARMED;
                  end
               end
            end
            ARMED: begin
               if (bus.din_valid) begin
                  if (bus.overlap == MODE_OVERLAP) begin
                     history_d = w_cand[PAT_W-2:0];
                  end else begin
                     state_d   = FILL;
                     pos_d     = '0;
                     history_d = '0;
                  end
               end
            end
            default: begin
               state_d   = FILL;
               pos_d     = '0;
               history_d = '0;
            end
         endcase
      end

      if (bus.clear) begin
         error_d = 1'b0;
      end else if (w_match) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FILL;
         pos_q     <= '0;
         history_q <= '0;
         error_q   <= 1'b0;
         overlap_q <= MODE_FRAMED;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         history_q <= history_d;
         error_q   <= error_d;
         overlap_q <= bus.overlap;
      end
   end

   serial_sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (w_match),
      .clr_i   (bus.clear),
      .count_o (bus.match_count)
   );

   assign bus.match = w_match;
   assign bus.error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_pattern_detector
//  Purpose  : Directed self-checking bench. Two detectors (CNT_W=8 and
//             CNT_W=2, PAT_W=3, PATTERN=111) receive identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_pattern_detector;

   logic clk;
   logic reset;

   int n_cmp;
   int n_bad;

   serial_pattern_detector_if #(.CNT_W(8)) bus_a ();
   serial_pattern_detector_if #(.CNT_W(2)) bus_b ();

   serial_pattern_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   serial_pattern_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic d, input logic v, input logic ov,
                        input logic cl);
      bus_a.Din = d;  bus_a.din_valid = v;  bus_a.overlap = ov;  bus_a.clear = cl;
      bus_b.Din = d;  bus_b.din_valid = v;  bus_b.overlap = ov;  bus_b.clear = cl;
   endtask

   // Inputs change at posedge+1; match sampled 2 time units later; the
   // cycle then ends 1 unit after the next rising edge.
   task automatic cyc(input string tag, input logic d, input logic v,
                      input logic ov, input logic cl, input logic exp_m);
      drive(d, v, ov, cl);
      #2;
      chk(tag, 32'(bus_a.match), 32'(exp_m));
      @(posedge clk);
      #1;
   endtask

   task automatic regs(input string tag, input logic exp_e,
                       input logic [7:0] exp_c);
      chk({tag, "_err"}, 32'(bus_a.error),       32'(exp_e));
      chk({tag, "_cnt"}, 32'(bus_a.match_count), 32'(exp_c));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      chk("rst_match", 32'(bus_a.match), 32'd0);
      regs("rst", 1'b0, 8'd0);
      chk("rst_cnt_b", 32'(bus_b.match_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Framed 1,1,1 -> match on the third bit only.
      cyc("t1_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t1_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      regs("t1_pre", 1'b0, 8'd0);
      cyc("t1_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      regs("t1", 1'b1, 8'd1);

      // Clear with a valid 1 present: discarded, no match.
      cyc("clr1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      regs("clr1", 1'b0, 8'd0);

      // Framed 0,1,1,1,1,1 -> frames 011 / 111, single match on bit 6.
      cyc("t2_b1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t2_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t2_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t2_b4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t2_b5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t2_b6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      regs("t2", 1'b1, 8'd1);

      // Overlap 1,1,1,1,1 -> matches on bits 3, 4, 5.
      cyc("t3_clr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("t3_b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t3_b2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t3_b3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("t3_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("t3_b5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      regs("t3", 1'b1, 8'd3);

      // Framed with valid gaps: 1,-,1,-,-,-,1 -> match on third valid bit.
      cyc("t4_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("t4_v1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t4_i1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("t4_v2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t4_i2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("t4_i3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("t4_i4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("t4_v3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      regs("t4", 1'b1, 8'd1);

      // Overlap toggle mid-frame discards the partial frame and that bit.
      cyc("t7_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t7_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t7_chg", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t7_b3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t7_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t7_b5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("t7_b6", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      regs("t7", 1'b1, 8'd3);

      // Back to framed, then reset asserted while a completing bit is present.
      cyc("t6_chg", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      regs("t6_kept", 1'b1, 8'd3);
      cyc("t6_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t6_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      chk("t6_armed", 32'(bus_a.match), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_m", 32'(bus_a.match), 32'd0);
      regs("t6_rst", 1'b0, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc("t6_r1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t6_r2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("t6_r3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      regs("t6", 1'b1, 8'd1);

      // Overlap, eight 1s: 6 matches; the 2-bit counter holds at 3.
      cyc("t5_clr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc("t5_bit", 1'b1, 1'b1, 1'b1, 1'b0, (i >= 2) ? 1'b1 : 1'b0);
         if (i == 4) begin
            chk("t5_b_cnt5", 32'(bus_b.match_count), 32'd3);
         end
      end
      chk("t5_b_sat", 32'(bus_b.match_count), 32'd3);
      chk("t5_b_err", 32'(bus_b.error), 32'd1);
      regs("t5_a", 1'b1, 8'd6);
      cyc("t5_clr2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_b_clr_cnt", 32'(bus_b.match_count), 32'd0);
      chk("t5_b_clr_err", 32'(bus_b.error), 32'd0);
      regs("t5_clr", 1'b0, 8'd0);
      cyc("t5_after", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t5_after2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t5_after3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      regs("t5_end", 1'b1, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
